// File: rtl/eth_arp_recv.sv
// Purpose: byte-wide MII/GMII receive parser that locks on preamble/SFD, filters on MAC and
//          EtherType, decodes the 28-byte ARP body and checks length/FCS; one pulse per frame.
// Latency: o_valid/o_drop are registered, high in the cycle after i_rx_dv is first sampled low.
// Backpressure: none; the PHY stream cannot be stalled, so every byte is consumed as it arrives.
// Optional FCS checking is built only when ETH_ARP_RECV_CRC_CHECK_EN is defined.
module eth_arp_recv #(
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] i_my_mac,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_dv,
    output logic [47:0] o_src_mac,
    output logic [1:0]  o_operation,
    output logic [47:0] o_SHA,
    output logic [31:0] o_SPA,
    output logic [47:0] o_THA,
    output logic [31:0] o_TPA,
    output logic        o_valid,
    output logic        o_drop
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        BODY,
        DROP
    } state_t;

    localparam logic [10:0] MAX_IDX = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN = 11'd64;

    state_t      state;
    logic [10:0] idx;          // bytes seen since the SFD
    logic [7:0]  prev;         // previous body byte, high half of 16-bit fields
    logic [39:0] dst_sh;       // first five destination bytes; the sixth is compared live
    logic [47:0] src_sh;
    logic [47:0] sha_sh;
    logic [47:0] tha_sh;
    logic [31:0] spa_sh;
    logic [31:0] tpa_sh;
    logic [1:0]  oper_sh;
    logic        field_bad;
    logic        reject;
    logic        crc_ok;

`ifdef ETH_ARP_RECV_CRC_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_next;

    // Reflected CRC-32 advanced by one byte, LSB first
    always_comb begin
        crc_next = crc ^ {24'h0, i_rx_data};
        for (int k = 0; k < 8; k++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB88320) : (crc_next >> 1);
        end
    end

    // CRC register: seeded at the SFD, runs over every body byte including the FCS
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 32'hFFFFFFFF;
        end else if (state == PREAMBLE && i_rx_dv && i_rx_data == 8'hD5) begin
            crc <= 32'hFFFFFFFF;
        end else if (state == BODY && i_rx_dv) begin
            crc <= crc_next;
        end
    end

    // Running the CRC over data plus FCS leaves the fixed CRC-32 residue
    assign crc_ok = (crc == 32'hDEBB20E3);
`else
    assign crc_ok = 1'b1;
`endif

    // Decide whether the byte at the current index kills the frame
    always_comb begin
        field_bad = 1'b0;
        case (idx)
            11'd5:  field_bad = ({dst_sh, i_rx_data} != i_my_mac) &&
                                ({dst_sh, i_rx_data} != 48'hFFFF_FFFF_FFFF);
            11'd13: field_bad = ({prev, i_rx_data} != 16'h0806);
            11'd15: field_bad = ({prev, i_rx_data} != 16'h0001);
            11'd17: field_bad = ({prev, i_rx_data} != 16'h0800);
            11'd18: field_bad = (i_rx_data != 8'd6);
            11'd19: field_bad = (i_rx_data != 8'd4);
            11'd21: field_bad = ({prev, i_rx_data} != 16'h0001) &&
                                ({prev, i_rx_data} != 16'h0002);
            default: field_bad = 1'b0;
        endcase
        reject = field_bad || (idx == MAX_IDX);
    end

    // Frame FSM: framing, field capture into shadows, end-of-frame verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 11'd0;
            prev        <= 8'd0;
            dst_sh      <= 40'd0;
            src_sh      <= 48'd0;
            sha_sh      <= 48'd0;
            tha_sh      <= 48'd0;
            spa_sh      <= 32'd0;
            tpa_sh      <= 32'd0;
            oper_sh     <= 2'd0;
            o_src_mac   <= 48'd0;
            o_operation <= 2'd0;
            o_SHA       <= 48'd0;
            o_SPA       <= 32'd0;
            o_THA       <= 48'd0;
            o_TPA       <= 32'd0;
            o_valid     <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_dv) begin
                        state <= (i_rx_data == 8'h55) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!i_rx_dv) begin
                        state <= IDLE;
                    end else if (i_rx_data == 8'hD5) begin
                        state <= BODY;
                        idx   <= 11'd0;
                    end else if (i_rx_data != 8'h55) begin
                        state <= DROP;
                    end
                end
                BODY: begin
                    if (!i_rx_dv) begin
                        state <= IDLE;
                        if (idx < MIN_LEN || !crc_ok) begin
                            o_drop <= 1'b1;
                        end else begin
                            o_valid     <= 1'b1;
                            o_src_mac   <= src_sh;
                            o_operation <= oper_sh;
                            o_SHA       <= sha_sh;
                            o_SPA       <= spa_sh;
                            o_THA       <= tha_sh;
                            o_TPA       <= tpa_sh;
                        end
                    end else if (reject) begin
                        state <= DROP;
                    end else begin
                        prev <= i_rx_data;
                        if (idx != 11'h7FF) begin
                            idx <= idx + 11'd1;
                        end
                        if (idx <= 11'd4)                   dst_sh  <= {dst_sh[31:0], i_rx_data};
                        if (idx >= 11'd6 && idx <= 11'd11)  src_sh  <= {src_sh[39:0], i_rx_data};
                        if (idx == 11'd21)                  oper_sh <= i_rx_data[1:0];
                        if (idx >= 11'd22 && idx <= 11'd27) sha_sh  <= {sha_sh[39:0], i_rx_data};
                        if (idx >= 11'd28 && idx <= 11'd31) spa_sh  <= {spa_sh[23:0], i_rx_data};
                        if (idx >= 11'd32 && idx <= 11'd37) tha_sh  <= {tha_sh[39:0], i_rx_data};
                        if (idx >= 11'd38 && idx <= 11'd41) tpa_sh  <= {tpa_sh[23:0], i_rx_data};
                    end
                end
                DROP: begin
                    if (!i_rx_dv) begin
                        o_drop <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_arp_recv.sv
// Bench for eth_arp_recv: directed frames plus randomized ARP frames judged by a
// frame-level reference model (whole-frame acceptance rules and CRC-32 of the payload).
module tb_eth_arp_recv;

    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] my_mac;
    logic [7:0]  rx_data;
    logic        rx_dv;
    logic [47:0] o_src_mac;
    logic [1:0]  o_operation;
    logic [47:0] o_SHA;
    logic [31:0] o_SPA;
    logic [47:0] o_THA;
    logic [31:0] o_TPA;
    logic        o_valid;
    logic        o_drop;

    eth_arp_recv #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_my_mac   (my_mac),
        .i_rx_data  (rx_data),
        .i_rx_dv    (rx_dv),
        .o_src_mac  (o_src_mac),
        .o_operation(o_operation),
        .o_SHA      (o_SHA),
        .o_SPA      (o_SPA),
        .o_THA      (o_THA),
        .o_TPA      (o_TPA),
        .o_valid    (o_valid),
        .o_drop     (o_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_valid = 0;
    int cnt_drop = 0;
    int exp_valid_cnt = 0;
    int exp_drop_cnt = 0;

    logic [7:0]  frm[$];
    logic [47:0] m_src, m_sha, m_tha;
    logic [31:0] m_spa, m_tpa;
    logic [1:0]  m_oper;

    // Every pulse seen on the outputs, for catching extra or stretched pulses
    always @(posedge clk) begin
        if (o_valid) cnt_valid <= cnt_valid + 1;
        if (o_drop)  cnt_drop  <= cnt_drop + 1;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        rx_data = d;
        rx_dv   = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] be(input int s, input int k);
        logic [47:0] v = 48'd0;
        for (int i = 0; i < k; i++) v = {v[39:0], frm[s+i]};
        return v;
    endfunction

    // Standard Ethernet CRC-32 of the first n bytes of the frame
    function automatic logic [31:0] crc_calc(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_be(input logic [47:0] v, input int k);
        for (int i = k - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    // Header + ARP body, zero padding up to len-4 bytes; FCS appended separately
    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                         input logic [47:0] tha, input logic [31:0] tpa, input int len);
        frm.delete();
        push_be(dst, 6); push_be(src, 6); push_be(48'(et), 2);
        push_be(48'h0001, 2); push_be(48'h0800, 2); push_be(48'h06, 1); push_be(48'h04, 1);
        push_be(48'(oper), 2); push_be(sha, 6); push_be(48'(spa), 4);
        push_be(tha, 6); push_be(48'(tpa), 4);
        while (frm.size() < len - 4) frm.push_back(8'h00);
        while (frm.size() > len - 4) void'(frm.pop_back());
    endtask

    task automatic add_fcs();
        logic [31:0] c = crc_calc(frm.size());
        frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    endtask

    // Frame-level acceptance rules
    function automatic bit model_valid(input logic [47:0] mac);
        int n = frm.size();
        logic [47:0] dst;
        logic [47:0] op;
        if (n < 64 || n > MAX_LEN) return 1'b0;
        dst = be(0, 6);
        if (dst != mac && dst != 48'hFFFF_FFFF_FFFF) return 1'b0;
        if (be(12, 2) != 48'h0806 || be(14, 2) != 48'h0001 || be(16, 2) != 48'h0800) return 1'b0;
        if (frm[18] != 8'd6 || frm[19] != 8'd4) return 1'b0;
        op = be(20, 2);
        if (op != 48'd1 && op != 48'd2) return 1'b0;
`ifdef ETH_ARP_RECV_CRC_CHECK_EN
        if (crc_calc(n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]}) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Preamble (optionally with a bad first byte), body, then one idle cycle
    task automatic send(input int pre_mode, input int rst_at, input int chg_at);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b = (i == 7) ? 8'hD5 : 8'h55;
            if (pre_mode == 1 && i == 0) b = 8'h12;
            drive(b, 1'b1);
        end
        for (int i = 0; i < frm.size(); i++) begin
            rst = (i == rst_at);
            if (i == chg_at) my_mac = ~my_mac;
            drive(frm[i], 1'b1);
            if (i == rst_at) begin
                m_src = '0; m_sha = '0; m_tha = '0; m_spa = '0; m_tpa = '0; m_oper = '0;
                chk("rst_no_valid", 48'(o_valid), 48'd0);
                chk("rst_no_drop", 48'(o_drop), 48'd0);
                chk("rst_src_zero", o_src_mac, 48'd0);
                chk("rst_spa_zero", 48'(o_SPA), 48'd0);
            end
        end
        rst = 1'b0;
        if (chg_at >= 0) my_mac = ~my_mac;
        drive(8'h00, 1'b0);
    endtask

    // Called in the cycle after rx_dv was first sampled low
    task automatic check_end(input bit exp_v);
        chk("valid_pulse", 48'(o_valid), 48'(exp_v));
        chk("drop_pulse", 48'(o_drop), 48'(!exp_v));
        chk("valid_count", 48'(cnt_valid), 48'(exp_valid_cnt));
        chk("drop_count", 48'(cnt_drop), 48'(exp_drop_cnt));
        if (exp_v) begin
            exp_valid_cnt++;
            m_src = be(6, 6); m_oper = frm[21][1:0]; m_sha = be(22, 6);
            m_spa = 32'(be(28, 4)); m_tha = be(32, 6); m_tpa = 32'(be(38, 4));
        end else begin
            exp_drop_cnt++;
        end
        chk("src_mac", o_src_mac, m_src);
        chk("operation", 48'(o_operation), 48'(m_oper));
        chk("sha", o_SHA, m_sha);
        chk("spa", 48'(o_SPA), 48'(m_spa));
        chk("tha", o_THA, m_tha);
        chk("tpa", 48'(o_TPA), 48'(m_tpa));
    endtask

    task automatic good_frame();
        build(48'hFFFF_FFFF_FFFF, 48'h010203040506, 16'h0806, 16'd1, 48'h010203040506,
              32'h0A00007B, 48'h0, 32'h0A000002, 64);
        add_fcs();
    endtask

    initial begin
        bit ev;
        rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00; my_mac = 48'h0A0B0C0D0E0F;
        m_src = '0; m_sha = '0; m_tha = '0; m_spa = '0; m_tpa = '0; m_oper = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 48'(o_valid), 48'd0);
        chk("reset_drop", 48'(o_drop), 48'd0);
        chk("reset_src", o_src_mac, 48'd0);
        chk("reset_sha", o_SHA, 48'd0);
        chk("reset_tpa", 48'(o_TPA), 48'd0);
        rst = 1'b0;
        drive(8'h00, 1'b0);

        // Broadcast request
        good_frame();
        ev = model_valid(my_mac);
        send(0, -1, -1);
        check_end(ev);
        chk("req_oper", 48'(o_operation), 48'd1);
        chk("req_spa", 48'(o_SPA), 48'h0A00007B);
        chk("req_tpa", 48'(o_TPA), 48'h0A000002);
        chk("req_sha", o_SHA, 48'h010203040506);
        chk("req_src", o_src_mac, 48'h010203040506);

        // Payload bit flip: rejected only when FCS checking is built
        good_frame();
        frm[30] = frm[30] ^ 8'h01;
        ev = model_valid(my_mac);
        send(0, -1, -1);
        check_end(ev);

        // Wrong EtherType
        build(48'hFFFF_FFFF_FFFF, 48'h1, 16'h0800, 16'd1, 48'h1, 32'h1, 48'h0, 32'h2, 64);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));

        // Unicast to some other station
        build(48'h020000000001, 48'h1, 16'h0806, 16'd1, 48'h1, 32'h1, 48'h0, 32'h2, 64);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));

        // Truncated to 50 bytes
        good_frame();
        while (frm.size() > 50) void'(frm.pop_back());
        send(0, -1, -1);
        check_end(model_valid(my_mac));

        // Reset in the middle of a frame, then a good frame
        good_frame();
        send(0, 20, -1);
        check_end(1'b0);
        good_frame();
        send(0, -1, -1);
        check_end(model_valid(my_mac));

        // Two replies separated by a single idle cycle
        build(my_mac, 48'hA1A2A3A4A5A6, 16'h0806, 16'd2, 48'hA1A2A3A4A5A6,
              32'hC0A80001, 48'h0A0B0C0D0E0F, 32'hC0A80002, 64);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));
        build(48'hFFFF_FFFF_FFFF, 48'hB1B2B3B4B5B6, 16'h0806, 16'd2, 48'hB1B2B3B4B5B6,
              32'hC0A80009, 48'h111213141516, 32'hC0A8000A, 70);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));
        chk("reply_oper", 48'(o_operation), 48'd2);

        // Unicast whose local MAC changes after the destination was judged
        build(my_mac, 48'h3, 16'h0806, 16'd1, 48'h3, 32'h3, 48'h0, 32'h4, 64);
        add_fcs();
        ev = model_valid(my_mac);
        send(0, -1, 30);
        check_end(ev);

        // Bad first preamble byte
        good_frame();
        send(1, -1, -1);
        check_end(1'b0);

        // Preamble abandoned: no pulse at all
        drive(8'h55, 1'b1); drive(8'h55, 1'b1); drive(8'h55, 1'b1);
        drive(8'h00, 1'b0);
        chk("pre_abort_valid", 48'(o_valid), 48'd0);
        chk("pre_abort_drop", 48'(o_drop), 48'd0);

        // Length boundaries: 63, MAX_LEN, MAX_LEN+1
        build(48'hFFFF_FFFF_FFFF, 48'h5, 16'h0806, 16'd1, 48'h5, 32'h5, 48'h0, 32'h6, 63);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));
        build(48'hFFFF_FFFF_FFFF, 48'h7, 16'h0806, 16'd2, 48'h7, 32'h7, 48'h0, 32'h8, MAX_LEN);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));
        build(48'hFFFF_FFFF_FFFF, 48'h9, 16'h0806, 16'd1, 48'h9, 32'h9, 48'h0, 32'hA, MAX_LEN + 1);
        add_fcs();
        send(0, -1, -1);
        check_end(model_valid(my_mac));

        // Randomized frames
        for (int t = 0; t < 30; t++) begin
            logic [47:0] dst;
            logic [15:0] et;
            int sel = $urandom_range(0, 3);
            dst = (sel == 0) ? 48'hFFFF_FFFF_FFFF :
                  (sel == 2) ? {$urandom, $urandom} : my_mac;
            et = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0806;
            build(dst, {$urandom, $urandom}, et, 16'($urandom_range(0, 3)),
                  {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom,
                  $urandom_range(46, 90));
            if ($urandom_range(0, 5) == 0) begin
                int p = $urandom_range(14, 19);
                frm[p] = frm[p] ^ 8'h10;
            end
            add_fcs();
            if ($urandom_range(0, 4) == 0) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
            ev = model_valid(my_mac);
            send(0, -1, -1);
            check_end(ev);
        end

        repeat (3) drive(8'h00, 1'b0);
        chk("final_valid_count", 48'(cnt_valid), 48'(exp_valid_cnt));
        chk("final_drop_count", 48'(cnt_drop), 48'(exp_drop_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
